regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have port Clock, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port Rst, input, 1 bit: synchronous, active-high reset, sampled on rising edge of Clock.
REQ-003 SHALL have port Clear_Start, input, 1: single-cycle request to zero all 16 registers.
REQ-004 SHALL have ports A_Valid, input, 1; A_Dst, input, 4; A_Data, input, 16: requester A (pipeline write-back).
REQ-005 SHALL have port A_Ready, output, 1: A transfer accepted this cycle when A_Valid & A_Ready.
REQ-006 SHALL have ports B_Valid, input, 1; B_Dst, input, 4; B_Data, input, 16: requester B (multi-cycle unit).
REQ-007 SHALL have port B_Ready, output, 1: B transfer accepted this cycle when B_Valid & B_Ready.
REQ-008 SHALL have ports RegWrite, output, 1; Dst, output, 4; Write_Data, output, 16: registered register-file write port.
REQ-009 SHALL have port Busy, output, 1: high while clear sequence runs.

Function
REQ-010 SHALL implement FSM states IDLE and CLEAR; reset state IDLE.
REQ-011 IDLE -> CLEAR SHALL occur when Clear_Start=1 in IDLE; Clear_Start SHALL be ignored in CLEAR.
REQ-012 CLEAR SHALL run exactly 16 cycles with 4-bit counter 0..15; counter wraps 15->0 and FSM returns to IDLE on the edge where counter=15.
REQ-013 In CLEAR, each cycle SHALL drive RegWrite=1, Dst=counter, Write_Data=16'h0000 (registered), Busy=1, A_Ready=B_Ready=0.
REQ-014 In IDLE, at most one of A_Ready/B_Ready SHALL be 1 per cycle; Ready is combinational from Valid inputs, state and priority flag.
REQ-015 Only one requester valid: that requester SHALL get Ready=1.
REQ-016 Both valid: grant SHALL go to requester not granted last (round-robin flag Last_B); flag updates only on an accepted transfer; reset value Last_B=1 (A wins first tie).
REQ-017 Neither valid: both Ready=0, RegWrite=0 next cycle.
REQ-018 Accepted transfer in cycle N SHALL appear on RegWrite=1, Dst, Write_Data in cycle N+1 (latency 1), held stable for the full cycle so the falling-edge register-file write captures it.
REQ-019 When RegWrite=0, Dst and Write_Data SHALL hold their last values.
REQ-020 Same Dst from both requesters SHALL be serialised in grant order; no merging or dropping.
REQ-021 Requesters SHALL hold Valid, Dst, Data stable until accepted; arbiter need not tolerate withdrawal.
REQ-022 Clear_Start in a cycle where a transfer is accepted: transfer SHALL complete (written in N+1) and CLEAR SHALL begin at N+1 with first clear write at N+2... no: CLEAR's first write (Dst=0) SHALL occur in cycle N+2, transfer write in N+1.
REQ-023 Throughput: one write per cycle in IDLE; a continuously valid requester facing a continuously valid competitor SHALL be granted every second cycle.

Reset
REQ-024 Rst=1 SHALL set state IDLE, counter 0, Last_B=1, RegWrite=0, Dst=4'h0, Write_Data=16'h0000, Busy=0.
REQ-025 While Rst=1, A_Ready=B_Ready=0; Rst SHALL override Clear_Start and any pending transfer.
REQ-026 Rst asserted mid-CLEAR SHALL abort the sequence; remaining registers are not written.

Verification
REQ-027 Rst 1 cycle, then A_Valid=1, A_Dst=3, A_Data=16'h1234 -> A_Ready=1 same cycle; next cycle RegWrite=1, Dst=3, Write_Data=16'h1234.
REQ-028 A and B valid 4 cycles (A_Dst=1, B_Dst=2) -> grants A,B,A,B; RegWrite high 4 consecutive cycles with Dst 1,2,1,2.
REQ-029 Clear_Start pulse in IDLE -> Busy=1 16 cycles, RegWrite=1 with Dst 0..15, Write_Data=0; A_Valid=1 meanwhile sees A_Ready=0 until Busy falls, then accepted.
REQ-030 Rst asserted at clear cycle 5 -> next cycle RegWrite=0, Busy=0, state IDLE; register 6..15 untouched.
REQ-031 Only B_Valid=1, B_Dst=15, B_Data=16'hFFFF, then idle -> one write Dst=15, Write_Data=16'hFFFF, then RegWrite=0 with Dst/Write_Data held.
REQ-032 Clear_Start same cycle as accepted A transfer (A_Dst=7) -> Dst=7 write in N+1, clear writes Dst=0..15 in N+2..N+17.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_if
// Description : Bundle of the clear request, the two write requesters, and
//               the registered register-file write port of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if;
    logic        Clear_Start;
    logic        A_Valid;
    logic [3:0]  A_Dst;
    logic [15:0] A_Data;
    logic        A_Ready;
    logic        B_Valid;
    logic [3:0]  B_Dst;
    logic [15:0] B_Data;
    logic        B_Ready;
    logic        RegWrite;
    logic [3:0]  Dst;
    logic [15:0] Write_Data;
    logic        Busy;

    // Requester / environment side
    modport master (
        output Clear_Start,
        output A_Valid, A_Dst, A_Data,
        input  A_Ready,
        output B_Valid, B_Dst, B_Data,
        input  B_Ready,
        input  RegWrite, Dst, Write_Data, Busy
    );

    // Arbiter side
    modport slave (
        input  Clear_Start,
        input  A_Valid, A_Dst, A_Data,
        output A_Ready,
        input  B_Valid, B_Dst, B_Data,
        output B_Ready,
        output RegWrite, Dst, Write_Data, Busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin arbiter between two register-file write
//               requesters with a 16-cycle clear-all sequence. The write
//               port is registered (one cycle after acceptance).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter (
    input  wire logic               Clock,
    input  wire logic               Rst,
    regfile_write_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [3:0] c_LAST_IDX = 4'd15;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_b_q, last_b_d;
    logic        regwrite_q, regwrite_d;
    logic [3:0]  dst_q, dst_d;
    logic [15:0] wdata_q, wdata_d;

    logic        w_a_grant;
    logic        w_b_grant;

    // Grant decision: combinational from Valid, state and the round-robin flag;
    // nothing is granted during reset or while clearing.
    always_comb begin
        w_a_grant = 1'b0;
        w_b_grant = 1'b0;
        if (state_q == IDLE && !Rst) begin
            if (bus.A_Valid && bus.B_Valid) begin
                w_a_grant = last_b_q;
                w_b_grant = !last_b_q;
            end else begin
                w_a_grant = bus.A_Valid;
                w_b_grant = bus.B_Valid;
            end
        end
    end

    // Next-state, clear counter, round-robin flag and write-port staging.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_b_d   = last_b_q;
        regwrite_d = 1'b0;
        dst_d      = dst_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (w_a_grant) begin
                    regwrite_d = 1'b1;
                    dst_d      = bus.A_Dst;
                    wdata_d    = bus.A_Data;
                    last_b_d   = 1'b0;
                end else if (w_b_grant) begin
                    regwrite_d = 1'b1;
                    dst_d      = bus.B_Dst;
                    wdata_d    = bus.B_Data;
                    last_b_d   = 1'b1;
                end
                // A transfer accepted in the same cycle still completes; the
                // first clear write lands one cycle after it.
                if (bus.Clear_Start) begin
                    state_d = CLEAR;
                    cnt_d   = 4'd0;
                end
            end
            CLEAR: begin
                regwrite_d = 1'b1;
                dst_d      = cnt_q;
                wdata_d    = 16'h0000;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == c_LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and registered write-port update; reset aborts any clear in flight.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            last_b_q   <= 1'b1;
            regwrite_q <= 1'b0;
            dst_q      <= 4'h0;
            wdata_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_b_q   <= last_b_d;
            regwrite_q <= regwrite_d;
            dst_q      <= dst_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.A_Ready    = w_a_grant;
    assign bus.B_Ready    = w_b_grant;
    assign bus.RegWrite   = regwrite_q;
    assign bus.Dst        = dst_q;
    assign bus.Write_Data = wdata_q;
    assign bus.Busy       = (state_q == CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed self-checking bench for regfile_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;
    logic Clock;
    logic Rst;
    int   errors;
    int   checks;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter u_dut (
        .Clock (Clock),
        .Rst   (Rst),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Clear_Start = 1'b0;
        bus.A_Valid     = 1'b0;
        bus.A_Dst       = 4'h0;
        bus.A_Data      = 16'h0000;
        bus.B_Valid     = 1'b0;
        bus.B_Dst       = 4'h0;
        bus.B_Data      = 16'h0000;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle_inputs();

        // ---------------- reset ----------------
        Rst = 1'b1;
        step();
        bus.A_Valid = 1'b1;
        #1;
        chk("rst_a_ready", {31'd0, bus.A_Ready}, 32'd0);
        step();
        chk("rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("rst_dst", {28'd0, bus.Dst}, 32'd0);
        chk("rst_wdata", {16'd0, bus.Write_Data}, 32'd0);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        Rst = 1'b0;

        // ---------------- single A write ----------------
        bus.A_Valid = 1'b1;
        bus.A_Dst   = 4'd3;
        bus.A_Data  = 16'h1234;
        #1;
        chk("a_only_ready", {31'd0, bus.A_Ready}, 32'd1);
        chk("a_only_b_ready", {31'd0, bus.B_Ready}, 32'd0);
        step();
        idle_inputs();
        chk("a_only_regwrite", {31'd0, bus.RegWrite}, 32'd1);
        chk("a_only_dst", {28'd0, bus.Dst}, 32'd3);
        chk("a_only_wdata", {16'd0, bus.Write_Data}, 32'h1234);

        // ---------------- single B write, then idle hold ----------------
        bus.B_Valid = 1'b1;
        bus.B_Dst   = 4'd15;
        bus.B_Data  = 16'hFFFF;
        #1;
        chk("b_only_ready", {31'd0, bus.B_Ready}, 32'd1);
        step();
        idle_inputs();
        chk("b_only_regwrite", {31'd0, bus.RegWrite}, 32'd1);
        chk("b_only_dst", {28'd0, bus.Dst}, 32'd15);
        chk("b_only_wdata", {16'd0, bus.Write_Data}, 32'hFFFF);
        step();
        chk("b_hold_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("b_hold_dst", {28'd0, bus.Dst}, 32'd15);
        chk("b_hold_wdata", {16'd0, bus.Write_Data}, 32'hFFFF);

        // ---------------- round robin: last grant was B, so A first ----------------
        bus.A_Valid = 1'b1; bus.A_Dst = 4'd1; bus.A_Data = 16'h1111;
        bus.B_Valid = 1'b1; bus.B_Dst = 4'd2; bus.B_Data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", {31'd0, bus.A_Ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_b_ready", {31'd0, bus.B_Ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            chk("rr_regwrite", {31'd0, bus.RegWrite}, 32'd1);
            chk("rr_dst", {28'd0, bus.Dst}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_wdata", {16'd0, bus.Write_Data}, (i % 2 == 0) ? 32'h1111 : 32'h2222);
        end
        idle_inputs();
        #1;
        chk("none_a_ready", {31'd0, bus.A_Ready}, 32'd0);
        chk("none_b_ready", {31'd0, bus.B_Ready}, 32'd0);
        step();
        chk("none_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("none_dst_hold", {28'd0, bus.Dst}, 32'd2);

        // ---------------- clear sequence with A waiting ----------------
        bus.Clear_Start = 1'b1;
        step();
        bus.Clear_Start = 1'b0;
        bus.A_Valid = 1'b1; bus.A_Dst = 4'd9; bus.A_Data = 16'hABCD;
        for (int k = 0; k < 16; k++) begin
            bus.Clear_Start = (k == 8) ? 1'b1 : 1'b0;
            #1;
            chk("clr_busy", {31'd0, bus.Busy}, 32'd1);
            chk("clr_a_ready", {31'd0, bus.A_Ready}, 32'd0);
            step();
            chk("clr_regwrite", {31'd0, bus.RegWrite}, 32'd1);
            chk("clr_dst", {28'd0, bus.Dst}, k);
            chk("clr_wdata", {16'd0, bus.Write_Data}, 32'd0);
        end
        bus.Clear_Start = 1'b0;
        #1;
        chk("clr_done_busy", {31'd0, bus.Busy}, 32'd0);
        chk("clr_done_a_ready", {31'd0, bus.A_Ready}, 32'd1);
        step();
        idle_inputs();
        chk("post_clr_regwrite", {31'd0, bus.RegWrite}, 32'd1);
        chk("post_clr_dst", {28'd0, bus.Dst}, 32'd9);
        chk("post_clr_wdata", {16'd0, bus.Write_Data}, 32'hABCD);
        step();

        // ---------------- reset aborts clear at cycle 5 ----------------
        bus.Clear_Start = 1'b1;
        step();
        bus.Clear_Start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("abort_dst", {28'd0, bus.Dst}, k);
        end
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("abort_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
        chk("abort_dst_rst", {28'd0, bus.Dst}, 32'd0);
        step();
        chk("abort_no_more_writes", {31'd0, bus.RegWrite}, 32'd0);
        chk("abort_idle_busy", {31'd0, bus.Busy}, 32'd0);

        // ---------------- clear coincident with accepted A ----------------
        bus.A_Valid = 1'b1; bus.A_Dst = 4'd7; bus.A_Data = 16'h7777;
        bus.Clear_Start = 1'b1;
        #1;
        chk("co_a_ready", {31'd0, bus.A_Ready}, 32'd1);
        step();
        idle_inputs();
        chk("co_regwrite", {31'd0, bus.RegWrite}, 32'd1);
        chk("co_dst", {28'd0, bus.Dst}, 32'd7);
        chk("co_wdata", {16'd0, bus.Write_Data}, 32'h7777);
        chk("co_busy", {31'd0, bus.Busy}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            step();
            chk("co_clr_regwrite", {31'd0, bus.RegWrite}, 32'd1);
            chk("co_clr_dst", {28'd0, bus.Dst}, k);
            chk("co_clr_wdata", {16'd0, bus.Write_Data}, 32'd0);
            chk("co_clr_busy", {31'd0, bus.Busy}, (k == 15) ? 32'd0 : 32'd1);
        end
        step();
        chk("co_end_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("co_end_dst_hold", {28'd0, bus.Dst}, 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
